// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extender with two-entry skid buffer
module imm_extend_pipe #(
    parameter int DATA_W        = 32,
    parameter int IMM_W         = 16,
    parameter int SHAMT_W       = 5,
    parameter int SHAMT_LSB     = 11,
    parameter bit LEGACY_DECODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_code,
    input  logic [2:0]        mode,
    input  logic [IMM_W-1:0]  instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic              out_err
);

    localparam int PAD_W = DATA_W - IMM_W;

    localparam logic [2:0] MODE_SEXT   = 3'd0;
    localparam logic [2:0] MODE_ZEXT   = 3'd1;
    localparam logic [2:0] MODE_SHAMT  = 3'd2;
    localparam logic [2:0] MODE_UPPER  = 3'd3;
    localparam logic [2:0] MODE_BRANCH = 3'd4;

    localparam logic [5:0] OP_SHIFT = 6'b000010;

    // ST_TWO is the only state where the skid register holds a word
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [2:0]        eff_mode;
    logic [DATA_W-1:0] sext_val;
    logic [DATA_W-1:0] new_imm;
    logic              new_err;

    logic [DATA_W-1:0] main_imm;
    logic              main_err;
    logic [DATA_W-1:0] skid_imm;
    logic              skid_err;

    logic              accept;
    logic              load_main_new;
    logic              load_main_skid;
    logic              load_skid;

    // in_ready comes straight from the state register, never from out_ready
    assign in_ready  = (state != ST_TWO);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign ext_imm   = main_imm;
    assign out_err   = main_err;

    assign sext_val = {{PAD_W{instr[IMM_W-1]}}, instr};

    // Choose the extension mode: legacy builds decode it from the opcode
    always_comb begin
        eff_mode = mode;
        if (LEGACY_DECODE) begin
            eff_mode = (op_code == OP_SHIFT) ? MODE_SHAMT : MODE_SEXT;
        end
    end

    // Compute the extended operand for the word currently offered
    always_comb begin
        new_imm = '0;
        new_err = 1'b0;
        case (eff_mode)
            MODE_SEXT:   new_imm = sext_val;
            MODE_ZEXT:   new_imm = {{PAD_W{1'b0}}, instr};
            MODE_SHAMT:  new_imm = {{(DATA_W-SHAMT_W){1'b0}}, instr[SHAMT_LSB +: SHAMT_W]};
            MODE_UPPER:  new_imm = {instr, {PAD_W{1'b0}}};
            MODE_BRANCH: new_imm = {sext_val[DATA_W-3:0], 2'b00};
            default: begin
                new_imm = '0;
                new_err = 1'b1;
            end
        endcase
    end

    // Buffer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and register load enables
    always_comb begin
        state_nx       = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nx      = ST_ONE;
                    load_main_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    load_main_new = 1'b1;
                end else if (accept) begin
                    state_nx  = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    state_nx       = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nx = ST_EMPTY;
            end
        endcase
    end

    // Main (output) register: loads a fresh word or the older skid word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_imm <= '0;
            main_err <= 1'b0;
        end else if (load_main_skid) begin
            main_imm <= skid_imm;
            main_err <= skid_err;
        end else if (load_main_new) begin
            main_imm <= new_imm;
            main_err <= new_err;
        end
    end

    // Skid register: catches the word accepted while the output is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_imm <= '0;
            skid_err <= 1'b0;
        end else if (load_skid) begin
            skid_imm <= new_imm;
            skid_err <= new_err;
        end
    end

endmodule
